// File: rtl/pc_trace_uart_sched_if.sv
// UART transmit handshake between the PC trace scheduler (master) and the uart (slave).
interface pc_trace_uart_sched_if;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       uart_busy;

    modport master (output tx_start, output tx_data, input uart_busy);
    modport slave  (input tx_start, input tx_data, output uart_busy);
endinterface

// File: rtl/pc_trace_uart_sched.sv
// Queues changed 6502 PC values and streams each one to the uart as four upper-case
// hex digits, optionally followed by CR LF.
module pc_trace_uart_sched #(
    parameter int unsigned DEPTH       = 8,
    parameter bit          EOL_EN      = 1'b1,
    parameter int unsigned ACK_TIMEOUT = 16
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         enable,
    input  logic [15:0]                  pc,
    pc_trace_uart_sched_if.master        uart,
    output logic [$clog2(DEPTH):0]       fifo_level,
    output logic [7:0]                   drop_count,
    output logic                         active
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [2:0]  LAST_IDX = EOL_EN ? 3'd5 : 3'd3;

    typedef enum logic [1:0] {StIdle, StSend, StWaitAck, StWaitDone} state_e;

    state_e         state_q, state_d;
    logic [15:0]    mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [15:0]    last_pc_q;
    logic [7:0]     drop_q;
    logic [15:0]    word_q, word_d;
    logic [2:0]     idx_q, idx_d;
    logic [TW-1:0]  timer_q, timer_d;
    logic [7:0]     tx_data_q;
    logic [7:0]     cur_char;
    logic           tx_start;
    logic           empty, full, pop, capture, push, drop;

    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        return (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction

    assign fifo_level = wr_ptr_q - rd_ptr_q;
    assign empty      = (fifo_level == '0);
    assign full       = (fifo_level == PW'(DEPTH));
    assign pop        = (state_q == StIdle) && !empty;
    assign capture    = enable && (pc != last_pc_q);
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push       = capture && (!full || pop);
    assign drop       = capture && !push;

    always_comb begin
        cur_char = 8'h0A;
        case (idx_q)
            3'd0:    cur_char = hex_char(word_q[15:12]);
            3'd1:    cur_char = hex_char(word_q[11:8]);
            3'd2:    cur_char = hex_char(word_q[7:4]);
            3'd3:    cur_char = hex_char(word_q[3:0]);
            3'd4:    cur_char = 8'h0D;
            default: cur_char = 8'h0A;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        idx_d    = idx_q;
        timer_d  = timer_q;
        tx_start = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    word_d  = mem_q[rd_ptr_q[AW-1:0]];
                    idx_d   = 3'd0;
                    state_d = StSend;
                end
            end
            StSend: begin
                if (!uart.uart_busy) begin
                    tx_start = 1'b1;
                    timer_d  = '0;
                    state_d  = StWaitAck;
                end
            end
            StWaitAck: begin
                // A uart that never raises busy still lets the line progress.
                if (uart.uart_busy || (timer_q == TW'(ACK_TIMEOUT - 1))) begin
                    state_d = StWaitDone;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StWaitDone: begin
                if (!uart.uart_busy) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = StIdle;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        state_d = StSend;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            last_pc_q <= 16'h0000;
            drop_q    <= 8'h00;
            word_q    <= 16'h0000;
            idx_q     <= 3'd0;
            timer_q   <= '0;
            tx_data_q <= 8'h00;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            idx_q   <= idx_d;
            timer_q <= timer_d;
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            if (capture) begin
                last_pc_q <= pc;
            end
            if (drop && (drop_q != 8'hFF)) begin
                drop_q <= drop_q + 8'd1;
            end
            if (tx_start) begin
                tx_data_q <= cur_char;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= pc;
        end
    end

    assign uart.tx_start = tx_start;
    assign uart.tx_data  = tx_start ? cur_char : tx_data_q;
    assign drop_count    = drop_q;
    assign active        = (state_q != StIdle);

endmodule

// File: tb/tb_pc_trace_uart_sched.sv
// Bench for pc_trace_uart_sched: queue-based model checked every cycle, plus directed
// line/byte expectations on an EOL_EN=1 and an EOL_EN=0 instance.
module tb_pc_trace_uart_sched;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned TO    = 16;
    localparam int          LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_n, enable, enable2;
    logic [15:0]   pc;
    logic [LW-1:0] fifo_level, fifo_level2;
    logic [7:0]    drop_count, drop_count2;
    logic          active, active2;
    logic          busy0 = 1'b0, busy1 = 1'b0;
    int            cnt0 = 0, cnt1 = 0;
    int            mode = 0;  // 0: uart busy 10 cycles/byte, 1: busy stuck high, 2: never busy

    int            n_tests = 0, n_fail = 0;
    bit            checking = 1'b0;
    int            cyc = 0;
    logic [7:0]    mon1[$], mon2[$], exp_q[$];
    int            t1[$];

    always #5 clk = ~clk;

    pc_trace_uart_sched_if u_if ();
    pc_trace_uart_sched_if u_if2 ();
    assign u_if.uart_busy  = busy0;
    assign u_if2.uart_busy = busy1;

    pc_trace_uart_sched #(.DEPTH(DEPTH), .EOL_EN(1'b1), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .pc(pc), .uart(u_if),
        .fifo_level(fifo_level), .drop_count(drop_count), .active(active)
    );

    pc_trace_uart_sched #(.DEPTH(DEPTH), .EOL_EN(1'b0), .ACK_TIMEOUT(TO)) dut_n (
        .clk(clk), .reset_n(reset_n), .enable(enable2), .pc(pc), .uart(u_if2),
        .fifo_level(fifo_level2), .drop_count(drop_count2), .active(active2)
    );

    // uart stand-ins: busy rises the cycle after tx_start and stays high 10 cycles
    always @(posedge clk) begin
        if (mode == 1) begin
            busy0 <= 1'b1; cnt0 <= 0;
        end else if (mode == 2) begin
            busy0 <= 1'b0; cnt0 <= 0;
        end else if (u_if.tx_start) begin
            busy0 <= 1'b1; cnt0 <= 9;
        end else if (cnt0 > 0) begin
            cnt0 <= cnt0 - 1;
        end else begin
            busy0 <= 1'b0;
        end
    end

    always @(posedge clk) begin
        if (mode == 1) begin
            busy1 <= 1'b1; cnt1 <= 0;
        end else if (mode == 2) begin
            busy1 <= 1'b0; cnt1 <= 0;
        end else if (u_if2.tx_start) begin
            busy1 <= 1'b1; cnt1 <= 9;
        end else if (cnt1 > 0) begin
            cnt1 <= cnt1 - 1;
        end else begin
            busy1 <= 1'b0;
        end
    end

    function automatic logic [7:0] line_char(input logic [15:0] w, input int i);
        logic [3:0] n;
        if (i == 4) return 8'h0D;
        if (i == 5) return 8'h0A;
        n = 4'((w >> (12 - 4 * i)) & 16'h000F);
        return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h41 + 8'(n) - 8'd10);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model for the EOL_EN=1 instance: pending PCs in a queue, one line in
    // flight, each char goes launch -> acknowledged -> uart idle again.
    logic [15:0] m_q[$];
    logic [15:0] m_last = '0, m_word = '0;
    logic [7:0]  m_held = '0;
    int          m_drop = 0, m_char = 0, m_stage = 0, m_timer = 0;
    bit          m_line = 1'b0, m_pop;

    initial forever begin
        @(posedge clk);
        if (!reset_n) begin
            m_q.delete();
            m_last = '0; m_drop = 0; m_line = 1'b0; m_char = 0;
            m_stage = 0; m_timer = 0; m_held = '0;
        end else begin
            m_pop = !m_line && (m_q.size() > 0);
            if (m_line) begin
                if (m_stage == 0) begin
                    if (!busy0) begin
                        m_held = line_char(m_word, m_char); m_stage = 1; m_timer = 0;
                    end
                end else if (m_stage == 1) begin
                    if (busy0 || m_timer == TO - 1) m_stage = 2;
                    else m_timer++;
                end else if (!busy0) begin
                    if (m_char == 5) m_line = 1'b0;
                    else begin m_char++; m_stage = 0; end
                end
            end
            if (m_pop) begin
                m_word = m_q.pop_front(); m_line = 1'b1; m_char = 0; m_stage = 0;
            end
            if (enable && pc != m_last) begin
                m_last = pc;
                if (m_q.size() < DEPTH) m_q.push_back(pc);
                else if (m_drop < 255) m_drop++;
            end
        end
    end

    initial forever begin : compare
        logic       e_start;
        logic [7:0] e_data;
        @(negedge clk);
        if (checking) begin
            e_start = m_line && (m_stage == 0) && !busy0;
            e_data  = e_start ? line_char(m_word, m_char) : m_held;
            check("tx_start", u_if.tx_start, e_start);
            check("tx_data", u_if.tx_data, e_data);
            check("fifo_level", fifo_level, m_q.size());
            check("drop_count", drop_count, m_drop);
            check("active", active, m_line);
        end
    end

    initial forever begin : monitor
        @(negedge clk);
        cyc++;
        if (u_if.tx_start === 1'b1) begin
            mon1.push_back(u_if.tx_data);
            t1.push_back(cyc);
        end
        if (u_if2.tx_start === 1'b1) mon2.push_back(u_if2.tx_data);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0; enable = 1'b0; enable2 = 1'b0; pc = 16'h0000;
        tick(2);
        mon1.delete(); mon2.delete(); t1.delete();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int k = 0;
        while (!(active === 1'b0 && fifo_level === '0) && k < budget) begin
            tick(1); k++;
        end
        check({name, " drained in budget"}, (k < budget), 1);
    endtask

    task automatic check_bytes(input string name, input logic [7:0] got[$],
                               input logic [7:0] exp[$]);
        check({name, " count"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++)
            check($sformatf("%s[%0d]", name, i), got[i], exp[i]);
    endtask

    task automatic exp_line(input logic [15:0] w, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(line_char(w, i));
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int k;
        reset_n = 1'b0; enable = 1'b0; enable2 = 1'b0; pc = 16'h0000;
        do_reset();
        checking = 1'b1;
        check("reset tx_start", u_if.tx_start, 0);
        check("reset tx_data", u_if.tx_data, 8'h00);
        check("reset fifo_level", fifo_level, 0);
        check("reset drop_count", drop_count, 0);
        check("reset active", active, 0);
        reset_n = 1'b1;

        // One line for 0x1C4F, then pc held: no second line
        mode = 0; enable = 1'b1; pc = 16'h1C4F;
        tick(3);
        wait_idle("t1", 400);
        check("t1 fifo_level", fifo_level, 0);
        tick(100);
        exp_q = '{8'h31, 8'h43, 8'h34, 8'h46, 8'h0D, 8'h0A};
        check_bytes("t1 bytes", mon1, exp_q);

        // Stuck uart: one line in flight, 8 queued, 4 of 12 dropped
        do_reset(); reset_n = 1'b1;
        mode = 1; enable = 1'b1;
        tick(2);
        pc = 16'h1000;
        tick(4);
        for (int i = 1; i <= 12; i++) begin
            pc = 16'h2000 + 16'(i);
            tick(1);
        end
        tick(2);
        check("t3 fifo_level", fifo_level, 8);
        check("t3 drop_count", drop_count, 4);
        check("t3 active", active, 1);
        mode = 0;
        tick(3);
        wait_idle("t3", 1500);
        exp_q.delete();
        exp_line(16'h1000, 6);
        for (int i = 1; i <= 8; i++) exp_line(16'h2000 + 16'(i), 6);
        check_bytes("t3 bytes", mon1, exp_q);

        // uart never busy: each byte released by the ack timeout
        do_reset(); reset_n = 1'b1;
        mode = 2; enable = 1'b1; pc = 16'h0A5F;
        tick(3);
        wait_idle("t4", 400);
        exp_q = '{8'h30, 8'h41, 8'h35, 8'h46, 8'h0D, 8'h0A};
        check_bytes("t4 bytes", mon1, exp_q);
        for (int i = 1; i < t1.size(); i++)
            check("t4 start spacing", t1[i] - t1[i-1], 18);

        // Reset after the second byte of a line
        do_reset(); reset_n = 1'b1;
        mode = 0; enable = 1'b1; pc = 16'h1234;
        tick(1);
        pc = 16'h5678;
        tick(1);
        enable = 1'b0;
        k = 0;
        while (mon1.size() < 2 && k < 100) begin tick(1); k++; end
        check("t5 second byte seen", (mon1.size() >= 2), 1);
        tick(3);
        reset_n = 1'b0;
        tick(1);
        check("t5 tx_start", u_if.tx_start, 0);
        check("t5 active", active, 0);
        check("t5 fifo_level", fifo_level, 0);
        reset_n = 1'b1;
        tick(100);
        check("t5 bytes after reset", mon1.size(), 2);

        // EOL_EN=0 instance: hex digits only, then drop counter saturation
        do_reset(); reset_n = 1'b1;
        mode = 0; enable2 = 1'b1; pc = 16'hABCD;
        tick(3);
        k = 0;
        while (active2 !== 1'b0 && k < 300) begin tick(1); k++; end
        check("t6 line done in budget", (k < 300), 1);
        tick(20);
        exp_q = '{8'h41, 8'h42, 8'h43, 8'h44};
        check_bytes("t6 bytes", mon2, exp_q);
        mode = 1;
        tick(2);
        for (int i = 0; i < 320; i++) begin
            pc = 16'h3000 + 16'(i);
            tick(1);
        end
        tick(2);
        check("t6 fifo_level", fifo_level2, 8);
        check("t6 drop_count", drop_count2, 8'hFF);
        check("t6 active", active2, 1);
        enable2 = 1'b0; mode = 0;

        // Busy pc stream: full-FIFO push/pop collisions, enable toggling
        do_reset(); reset_n = 1'b1;
        mode = 0; enable = 1'b1;
        for (int i = 0; i < 600; i++) begin
            pc = 16'($urandom_range(0, 5)) * 16'h1111;
            if (i % 97 == 50) enable = ~enable;
            tick(1);
        end
        enable = 1'b0;
        wait_idle("t7", 2500);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
